// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
// Shared constants, FSM state type and the field-packing helper for the
// FP32 normalize/pack back end.
// -----------------------------------------------------------------------------
package fp_pkg;

    localparam int unsigned FP32_EXP_W  = 8;
    localparam int unsigned FP32_MANT_W = 23;

    localparam logic [FP32_EXP_W-1:0] EXP_MAX        = 8'hFF;
    // Denormals behave as if their exponent were 1.
    localparam logic [FP32_EXP_W-1:0] EXP_DENORM_EFF = 8'd1;
    localparam logic [31:0]           POS_ZERO       = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        DONE
    } state_e;

    function automatic logic [31:0] fp_pack_word(
        input logic                   sign,
        input logic [FP32_EXP_W-1:0]  exp,
        input logic [FP32_MANT_W-1:0] frac
    );
        return {sign, exp, frac};
    endfunction

endpackage

// File: rtl/fp_normalize_seq_if.sv
// -----------------------------------------------------------------------------
// fp_normalize_seq_if
// Upstream (sum/exponent/sign) and downstream (result) valid/ready handshakes.
//   slave  : the normalizer side (consumes operands, produces results)
//   master : the environment side (adder stage + result consumer)
// -----------------------------------------------------------------------------
interface fp_normalize_seq_if #(
    parameter int unsigned MANT_W = 23,
    parameter int unsigned EXP_W  = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic [MANT_W+1:0]       sum_mant;
    logic [EXP_W-1:0]        exp_in;
    logic                    sign_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [EXP_W+MANT_W:0]   result;
    logic                    overflow;
    logic                    busy;

    modport slave (
        input  in_valid, sum_mant, exp_in, sign_in, out_ready,
        output in_ready, out_valid, result, overflow, busy
    );

    modport master (
        output in_valid, sum_mant, exp_in, sign_in, out_ready,
        input  in_ready, out_valid, result, overflow, busy
    );
endinterface

// File: rtl/fp_pack.sv
// -----------------------------------------------------------------------------
// fp_pack
// Combinational decision for one NORM cycle: decides whether the current
// mant/exp state is terminal and, if so, what packed word to emit.
//   i_sign, i_exp, i_mant : current working registers
//   o_final               : this cycle finishes normalization
//   o_result, o_overflow  : packed word / exponent-overflow flag when final
// -----------------------------------------------------------------------------
module fp_pack
    import fp_pkg::*;
#(
    parameter int unsigned MANT_W = FP32_MANT_W,
    parameter int unsigned EXP_W  = FP32_EXP_W
) (
    input  logic                  i_sign,
    input  logic [EXP_W-1:0]      i_exp,
    input  logic [MANT_W+1:0]     i_mant,
    output logic [EXP_W+MANT_W:0] o_result,
    output logic                  o_overflow,
    output logic                  o_final
);

    logic [EXP_W-1:0] w_exp_inc;

    always_comb begin
        w_exp_inc  = i_exp + 1'b1;
        o_result   = POS_ZERO;
        o_overflow = 1'b0;
        o_final    = 1'b1;
        if (i_exp == EXP_MAX) begin
            // Inf/NaN input passes straight through.
            o_result = fp_pack_word(i_sign, EXP_MAX, i_mant[MANT_W-1:0]);
        end else if (i_mant == '0) begin
            o_result = POS_ZERO;
        end else if (i_mant[MANT_W+1]) begin
            // Carry out: one right shift, LSB truncated.
            if (w_exp_inc == EXP_MAX) begin
                o_result   = fp_pack_word(i_sign, EXP_MAX, '0);
                o_overflow = 1'b1;
            end else begin
                o_result = fp_pack_word(i_sign, w_exp_inc, i_mant[MANT_W:1]);
            end
        end else if (i_mant[MANT_W]) begin
            o_result = fp_pack_word(i_sign, i_exp, i_mant[MANT_W-1:0]);
        end else if (i_exp == EXP_DENORM_EFF) begin
            o_result = fp_pack_word(i_sign, '0, i_mant[MANT_W-1:0]);
        end else begin
            o_final = 1'b0;
        end
    end

endmodule

// File: rtl/fp_normalize_seq.sv
// -----------------------------------------------------------------------------
// fp_normalize_seq
// Iterative normalizer + IEEE-754 single packer for the FP adder back end.
// One left shift per cycle on cancellation; carry, zero, Inf/NaN and
// already-normal sums finish in one cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : operand in (in_valid/in_ready), result out (out_valid/
//                out_ready), overflow flag and busy status
// -----------------------------------------------------------------------------
module fp_normalize_seq
    import fp_pkg::*;
#(
    parameter int unsigned MANT_W = FP32_MANT_W,
    parameter int unsigned EXP_W  = FP32_EXP_W
) (
    input logic               clk,
    input logic               rst_n,
    fp_normalize_seq_if.slave bus
);

    localparam int unsigned SUM_W = MANT_W + 2;
    localparam int unsigned RES_W = 1 + EXP_W + MANT_W;

    state_e             r_state;
    logic [SUM_W-1:0]   r_mant;
    logic [EXP_W-1:0]   r_exp;
    logic               r_sign;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;
    logic [RES_W-1:0]   r_result;
    logic               r_overflow;

    logic [RES_W-1:0]   w_result;
    logic               w_overflow;
    logic               w_final;

    fp_pack #(
        .MANT_W (MANT_W),
        .EXP_W  (EXP_W)
    ) u_pack (
        .i_sign     (r_sign),
        .i_exp      (r_exp),
        .i_mant     (r_mant),
        .o_result   (w_result),
        .o_overflow (w_overflow),
        .o_final    (w_final)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_mant      <= '0;
            r_exp       <= '0;
            r_sign      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_result    <= '0;
            r_overflow  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_mant     <= bus.sum_mant;
                        r_exp      <= (bus.exp_in == '0) ? EXP_DENORM_EFF : bus.exp_in;
                        r_sign     <= bus.sign_in;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= NORM;
                    end
                end
                NORM: begin
                    if (w_final) begin
                        r_result    <= w_result;
                        r_overflow  <= w_overflow;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        // Exponent cannot drop below 1 here: fp_pack stops at 1.
                        r_mant <= r_mant << 1;
                        r_exp  <= r_exp - 1'b1;
                    end
                end
                DONE: begin
                    // No accept on this edge; in_ready is seen next cycle.
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_overflow  <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.overflow  = r_overflow;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_fp_normalize_seq.sv
// -----------------------------------------------------------------------------
// tb_fp_normalize_seq
// Directed + random operands against an arithmetic reference model of the
// normalize/pack rules, including latency, backpressure and mid-op reset.
// -----------------------------------------------------------------------------
module tb_fp_normalize_seq;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    fp_normalize_seq_if bus_if ();

    fp_normalize_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference: find the leading one, normalize arithmetically, clamp at
    // the denormal exponent, and derive latency from the shift count.
    task automatic ref_model(input logic [24:0] sum, input logic [7:0] exp_in, input logic sign,
                             output logic [31:0] res, output logic ovf, output int lat);
        int          e;
        int          p;
        int          n;
        logic [24:0] m;
        e   = (exp_in == 0) ? 1 : int'(exp_in);
        ovf = 1'b0;
        lat = 1;
        if (e == 255) begin
            res = {sign, 8'hFF, sum[22:0]};
        end else if (sum == 0) begin
            res = 32'h0;
        end else if (sum >= 25'h1000000) begin
            m = sum >> 1;
            if (e + 1 == 255) begin
                res = {sign, 8'hFF, 23'h0};
                ovf = 1'b1;
            end else begin
                res = {sign, 8'(e + 1), m[22:0]};
            end
        end else begin
            p = 0;
            for (int i = 0; i < 24; i++) if (sum[i]) p = i;
            n = 23 - p;
            if (n <= e - 1) begin
                m   = sum << n;
                res = {sign, 8'(e - n), m[22:0]};
                lat = n + 1;
            end else begin
                m   = sum << (e - 1);
                res = {sign, 8'h00, m[22:0]};
                lat = e;
            end
        end
    endtask

    task automatic run_op(input logic [24:0] sum, input logic [7:0] exp_in, input logic sign,
                          input int hold, input string tag);
        logic [31:0] exp_res;
        logic        exp_ovf;
        int          exp_lat;
        int          lat;
        int          guard;
        ref_model(sum, exp_in, sign, exp_res, exp_ovf, exp_lat);

        guard = 0;
        while (!bus_if.in_ready && guard < 10) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check_eq({tag, ".in_ready"}, 32'(bus_if.in_ready), 32'd1);

        bus_if.sum_mant  = sum;
        bus_if.exp_in    = exp_in;
        bus_if.sign_in   = sign;
        bus_if.in_valid  = 1'b1;
        bus_if.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;

        lat = 0;
        while (!bus_if.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, ".result"}, bus_if.result, exp_res);
        check_eq({tag, ".overflow"}, 32'(bus_if.overflow), 32'(exp_ovf));

        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_eq({tag, ".hold_valid"}, 32'(bus_if.out_valid), 32'd1);
            check_eq({tag, ".hold_result"}, bus_if.result, exp_res);
            check_eq({tag, ".hold_in_ready"}, 32'(bus_if.in_ready), 32'd0);
            check_eq({tag, ".hold_busy"}, 32'(bus_if.busy), 32'd1);
        end

        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.out_ready = 1'b0;
        check_eq({tag, ".drain_valid"}, 32'(bus_if.out_valid), 32'd0);
        check_eq({tag, ".drain_in_ready"}, 32'(bus_if.in_ready), 32'd1);
        check_eq({tag, ".drain_busy"}, 32'(bus_if.busy), 32'd0);
    endtask

    initial begin
        logic [24:0] sum;
        logic [7:0]  e;
        int          k;
        int          sel;

        n_checks         = 0;
        n_errors         = 0;
        bus_if.in_valid  = 1'b0;
        bus_if.sum_mant  = '0;
        bus_if.exp_in    = '0;
        bus_if.sign_in   = 1'b0;
        bus_if.out_ready = 1'b0;
        rst_n            = 1'b0;
        #12;
        check_eq("reset.in_ready", 32'(bus_if.in_ready), 32'd1);
        check_eq("reset.out_valid", 32'(bus_if.out_valid), 32'd0);
        check_eq("reset.result", bus_if.result, 32'h0);
        check_eq("reset.overflow", 32'(bus_if.overflow), 32'd0);
        check_eq("reset.busy", 32'(bus_if.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(25'h1000000, 8'd127, 1'b0, 0, "carry");
        run_op(25'h0200000, 8'd127, 1'b0, 0, "cancel");
        run_op(25'h0000000, 8'd100, 1'b1, 0, "zero");
        run_op(25'h0100000, 8'd2,   1'b0, 0, "denorm");
        run_op(25'h1800000, 8'd254, 1'b1, 5, "overflow");
        run_op(25'h0000001, 8'd127, 1'b0, 2, "worst");
        run_op(25'h0ABCDEF, 8'd255, 1'b1, 0, "passthru");
        run_op(25'h0000040, 8'd0,   1'b0, 0, "exp0");

        // Reset while normalizing a long cancellation.
        bus_if.sum_mant = 25'h0000001;
        bus_if.exp_in   = 8'd127;
        bus_if.sign_in  = 1'b0;
        bus_if.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_eq("midop.busy", 32'(bus_if.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("midop.out_valid", 32'(bus_if.out_valid), 32'd0);
        check_eq("midop.result", bus_if.result, 32'h0);
        check_eq("midop.in_ready", 32'(bus_if.in_ready), 32'd1);
        check_eq("midop.busy_clr", 32'(bus_if.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(25'h0200000, 8'd127, 1'b1, 1, "after_rst");

        for (int t = 0; t < 150; t++) begin
            k   = $urandom_range(25, 0);
            sum = 25'($urandom) & ((25'd1 << k) - 25'd1);
            sel = $urandom_range(9, 0);
            case (sel)
                0:       e = 8'd0;
                1:       e = 8'd1;
                2:       e = 8'd2;
                3:       e = 8'd254;
                4:       e = 8'd255;
                default: e = 8'($urandom);
            endcase
            run_op(sum, e, 1'($urandom), $urandom_range(3, 0), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
